// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 instruction/function codes, CC type and shared condition evaluation
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] ALU_MUL = 4'h4;

  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = 3'b100;

  function automatic logic cond_legal(input logic [3:0] ifun);
    return ifun <= C_G;
  endfunction

  // Shared with the branch predictor, so it only looks at ifun and the flags.
  function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (ifun)
      C_ALWAYS: return 1'b1;
      C_LE:     return lt | cc.zf;
      C_L:      return lt;
      C_E:      return cc.zf;
      C_NE:     return !cc.zf;
      C_GE:     return !lt;
      C_G:      return !lt & !cc.zf;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// rtl/exec_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module exec_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic [WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
  // Product is presented combinationally on the last step so the caller can latch it that edge.
  assign o_product  = w_acc_next;
  assign o_done     = r_run && (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      r_acc <= w_acc_next;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage_pipe.sv
// rtl/execute_stage_pipe.sv - Y86-64 execute stage with CC register and output slot; EXEC_MUL_EN adds mulq
module execute_stage_pipe
  import y86_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int STACK_STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_icode,
  output logic [WIDTH-1:0] out_valE,
  output logic [WIDTH-1:0] out_valA,
  output logic             out_cnd,
  output logic             out_err,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

  logic             r_out_valid;
  logic [3:0]       r_out_icode;
  logic [WIDTH-1:0] r_out_valE;
  logic [WIDTH-1:0] r_out_valA;
  logic             r_out_cnd;
  logic             r_out_err;
  cc_t              r_cc;

  logic             w_accept;
  logic             w_busy;
  logic             w_err;
  logic             w_cnd;
  logic             w_of;
  logic             w_is_mul;
  logic [WIDTH-1:0] w_valE;
  cc_t              w_cc_op;
  logic             w_cc_we;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0] w_mul_valA;
  logic             w_mul_set_cc;

  assign in_ready = !w_busy && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_valE   = '0;
    w_err    = 1'b0;
    w_cnd    = 1'b0;
    w_of     = 1'b0;
    w_is_mul = 1'b0;
    case (icode)
      I_HALT, I_NOP: w_valE = '0;
      I_CMOVXX, I_JXX: begin
        if (cond_legal(ifun)) begin
          w_cnd = cond_eval(ifun, r_cc);
          if (icode == I_CMOVXX) w_valE = valA;
        end else begin
          w_err = 1'b1;
        end
      end
      I_IRMOVQ:           w_valE = valC;
      I_RMMOVQ, I_MRMOVQ: w_valE = valB + valC;
      I_OPQ: begin
        case (ifun)
          ALU_ADD: begin
            w_valE = valB + valA;
            w_of   = (valA[WIDTH-1] == valB[WIDTH-1]) && (w_valE[WIDTH-1] != valB[WIDTH-1]);
          end
          ALU_SUB: begin
            w_valE = valB - valA;
            w_of   = (valA[WIDTH-1] != valB[WIDTH-1]) && (w_valE[WIDTH-1] != valB[WIDTH-1]);
          end
          ALU_AND: w_valE = valB & valA;
          ALU_XOR: w_valE = valB ^ valA;
`ifdef EXEC_MUL_EN
          ALU_MUL: w_is_mul = 1'b1;
`endif
          default: w_err = 1'b1;
        endcase
      end
      I_CALL, I_PUSHQ: w_valE = valB - STEP;
      I_RET, I_POPQ:   w_valE = valB + STEP;
      default:         w_err = 1'b1;
    endcase
  end

  assign w_cc_op = {w_valE == '0, w_valE[WIDTH-1], w_of};
  assign w_cc_we = w_accept && (icode == I_OPQ) && set_cc && !w_err && !w_is_mul;

`ifdef EXEC_MUL_EN
  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MUL_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_mul_valA;
  logic             r_mul_set_cc;

  assign w_busy       = (r_state == S_MUL_BUSY);
  assign w_mul_valA   = r_mul_valA;
  assign w_mul_set_cc = r_mul_set_cc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mul_valA   <= '0;
      r_mul_set_cc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state      <= S_MUL_BUSY;
            r_mul_valA   <= valA;
            r_mul_set_cc <= set_cc;
          end
        end
        S_MUL_BUSY: if (w_mul_done) r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  exec_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (w_accept && w_is_mul),
    .i_a       (valB),
    .i_b       (valA),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );
`else
  assign w_busy        = 1'b0;
  assign w_mul_done    = 1'b0;
  assign w_mul_product = '0;
  assign w_mul_valA    = '0;
  assign w_mul_set_cc  = 1'b0;
`endif

  // A multiply only completes into an empty slot: accepting it required the slot to drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_icode <= I_NOP;
      r_out_valE  <= '0;
      r_out_valA  <= '0;
      r_out_cnd   <= 1'b0;
      r_out_err   <= 1'b0;
      r_cc        <= CC_RESET;
    end else begin
      if (w_accept && !w_is_mul) begin
        r_out_valid <= 1'b1;
        r_out_icode <= icode;
        r_out_valE  <= w_valE;
        r_out_valA  <= valA;
        r_out_cnd   <= w_cnd;
        r_out_err   <= w_err;
      end else if (w_mul_done) begin
        r_out_valid <= 1'b1;
        r_out_icode <= I_OPQ;
        r_out_valE  <= w_mul_product;
        r_out_valA  <= w_mul_valA;
        r_out_cnd   <= 1'b0;
        r_out_err   <= 1'b0;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_cc_we) begin
        r_cc <= w_cc_op;
      end else if (w_mul_done && w_mul_set_cc) begin
        r_cc <= {w_mul_product == '0, w_mul_product[WIDTH-1], 1'b0};
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_icode = r_out_icode;
  assign out_valE  = r_out_valE;
  assign out_valA  = r_out_valA;
  assign out_cnd   = r_out_cnd;
  assign out_err   = r_out_err;
  assign cc_zf     = r_cc.zf;
  assign cc_sf     = r_cc.sf;
  assign cc_of     = r_cc.of;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// tb/tb_execute_stage_pipe.sv - scoreboard bench for execute_stage_pipe (mul tests under EXEC_MUL_EN)
module tb_execute_stage_pipe;

  localparam int W = 64;
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA;
  logic [W-1:0] valB;
  logic [W-1:0] valC;
  logic         set_cc;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_icode;
  logic [W-1:0] out_valE;
  logic [W-1:0] out_valA;
  logic         out_cnd;
  logic         out_err;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;

  typedef struct {
    string        name;
    logic [3:0]   icode;
    logic [W-1:0] valE;
    logic [W-1:0] valA;
    logic         cnd;
    logic         err;
    logic         zf;
    logic         sf;
    logic         of;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic m_zf, m_sf, m_of;

  execute_stage_pipe #(.WIDTH(W), .STACK_STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .icode     (icode),
    .ifun      (ifun),
    .valA      (valA),
    .valB      (valB),
    .valC      (valC),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_icode (out_icode),
    .out_valE  (out_valE),
    .out_valA  (out_valA),
    .out_cnd   (out_cnd),
    .out_err   (out_err),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: flags evaluated before, and updated by, this instruction.
  task automatic predict(input string nm, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic sc, output exp_t e);
    logic signed [W:0] full;
    logic lt, cond, ovf;
    e.name = nm; e.icode = ic; e.valA = a; e.valE = '0; e.cnd = 1'b0; e.err = 1'b0;
    lt = m_sf ^ m_of;
    ovf = 1'b0;
    case (fn)
      4'd0: cond = 1'b1;
      4'd1: cond = lt | m_zf;
      4'd2: cond = lt;
      4'd3: cond = m_zf;
      4'd4: cond = !m_zf;
      4'd5: cond = !lt;
      4'd6: cond = !lt && !m_zf;
      default: cond = 1'b0;
    endcase
    if (ic > 4'hB) e.err = 1'b1;
    else if (ic == 4'h2 || ic == 4'h7) begin
      if (fn > 4'd6) e.err = 1'b1;
      else begin
        e.cnd = cond;
        if (ic == 4'h2) e.valE = a;
      end
    end else if (ic == 4'h6) begin
      case (fn)
        4'd0: begin full = {b[W-1], b} + {a[W-1], a}; e.valE = full[W-1:0]; ovf = full[W] != full[W-1]; end
        4'd1: begin full = {b[W-1], b} - {a[W-1], a}; e.valE = full[W-1:0]; ovf = full[W] != full[W-1]; end
        4'd2: e.valE = b & a;
        4'd3: e.valE = b ^ a;
        4'd4: if (MUL_EN) e.valE = b * a; else e.err = 1'b1;
        default: e.err = 1'b1;
      endcase
      if (!e.err && sc) begin
        m_zf = (e.valE == '0);
        m_sf = e.valE[W-1];
        m_of = ovf;
      end
    end else begin
      case (ic)
        4'h3:       e.valE = c;
        4'h4, 4'h5: e.valE = b + c;
        4'h8, 4'hA: e.valE = b - 64'd8;
        4'h9, 4'hB: e.valE = b + 64'd8;
        default:    e.valE = '0;
      endcase
    end
    e.zf = m_zf; e.sf = m_sf; e.of = m_of;
  endtask

  task automatic send(input string nm, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic sc, output int waits);
    exp_t e;
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; set_cc = sc; in_valid = 1'b1;
    waits = 0;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #2;
      waits++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL %s accept_timeout: in_ready=%b after %0d cycles, required 1", nm, in_ready, waits);
      in_valid = 1'b0;
      return;
    end
    predict(nm, ic, fn, a, b, c, sc, e);
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && out_valid && out_ready) begin
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: icode=%h valE=%h with empty scoreboard", out_icode, out_valE);
      end else begin
        e = sb.pop_front();
        if ({out_icode, out_valE, out_valA, out_cnd, out_err} !== {e.icode, e.valE, e.valA, e.cnd, e.err})
          $display("FAIL %s result: got icode=%h valE=%h valA=%h cnd=%b err=%b, required icode=%h valE=%h valA=%h cnd=%b err=%b",
                   e.name, out_icode, out_valE, out_valA, out_cnd, out_err, e.icode, e.valE, e.valA, e.cnd, e.err);
        else n_pass++;
        n_total++;
        if ({cc_zf, cc_sf, cc_of} !== {e.zf, e.sf, e.of})
          $display("FAIL %s cc: got zf/sf/of=%b%b%b, required %b%b%b", e.name, cc_zf, cc_sf, cc_of, e.zf, e.sf, e.of);
        else n_pass++;
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    sb.delete();
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin tick(); n++; end
    n_total++;
    if (sb.size() != 0) $display("FAIL %s drain: %0d results outstanding, required 0", nm, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    apply_reset();
    n_total++;
    if ({out_valid, out_icode, out_valE, out_valA, out_cnd, out_err} !== {1'b0, 4'h1, {W{1'b0}}, {W{1'b0}}, 1'b0, 1'b0})
      $display("FAIL reset_outputs: got valid=%b icode=%h valE=%h valA=%h cnd=%b err=%b, required 0 1 0 0 0 0",
               out_valid, out_icode, out_valE, out_valA, out_cnd, out_err);
    else n_pass++;
    n_total++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) $display("FAIL reset_cc: got %b%b%b, required 100", cc_zf, cc_sf, cc_of);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_flags();
    int w;
    send("sub_5_5",   4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1, w);
    send("je",        4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b1, w);
    send("add_ovf",   4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, w);
    send("jl",        4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b1, w);
    send("jge",       4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 1'b1, w);
    send("cmovle",    4'h2, 4'h1, 64'h1234, 64'd0, 64'd0, 1'b1, w);
    send("sub_neg",   4'h6, 4'h1, 64'd9, 64'd3, 64'd0, 1'b1, w);
    send("jg",        4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 1'b1, w);
    send("sub_ovf",   4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b1, w);
    send("cmovne",    4'h2, 4'h4, 64'hABCD, 64'd0, 64'd0, 1'b1, w);
    drain("flags");
  endtask

  task automatic test_stack_and_moves();
    int w;
    send("pushq",     4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1, w);
    send("popq",      4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1, w);
    send("call",      4'h8, 4'h0, 64'd0, 64'd4, 64'd0, 1'b1, w);
    send("ret",       4'h9, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b1, w);
    send("rmmovq",    4'h4, 4'h0, 64'd7, 64'h1000, 64'h24, 1'b1, w);
    send("mrmovq",    4'h5, 4'h0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b1, w);
    send("irmovq",    4'h3, 4'h0, 64'd0, 64'd0, 64'hDEAD_BEEF, 1'b1, w);
    send("nop",       4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1, w);
    send("halt",      4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 1'b1, w);
    send("and_nocc",  4'h6, 4'h2, 64'd1, 64'd2, 64'd0, 1'b0, w);
    send("jle_after", 4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 1'b1, w);
    send("xor_zero",  4'h6, 4'h3, 64'hF0F0, 64'hF0F0, 64'd0, 1'b1, w);
    drain("stack");
  endtask

  task automatic test_errors();
    int w;
    send("icode_c",   4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 1'b1, w);
    send("opq_f5",    4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 1'b1, w);
    send("jxx_f7",    4'h7, 4'h7, 64'd1, 64'd2, 64'd0, 1'b1, w);
    send("cmov_f9",   4'h2, 4'h9, 64'd1, 64'd2, 64'd0, 1'b1, w);
    send("icode_f",   4'hF, 4'hF, 64'd1, 64'd2, 64'd3, 1'b1, w);
`ifndef EXEC_MUL_EN
    send("mulq_off",  4'h6, 4'h4, 64'd7, 64'd6, 64'd0, 1'b1, w);
`endif
    drain("errors");
  endtask

  task automatic test_hold_and_back_to_back();
    int w;
    logic [2*W+6:0] snap;
    out_ready = 1'b0;
    send("hold_xor", 4'h6, 4'h3, 64'hF0, 64'hFF, 64'd0, 1'b1, w);
    snap = {out_valid, out_icode, out_valE, out_valA, out_cnd, out_err};
    icode = 4'h6; ifun = 4'h0; valA = 64'd1; valB = 64'd2; set_cc = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if ({out_valid, out_icode, out_valE, out_valA, out_cnd, out_err} !== snap)
        $display("FAIL hold_stable cycle %0d: got valE=%h valid=%b, required valE=%h valid=1", i, out_valE, out_valid, snap[W+W+1:W+2]);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b0) $display("FAIL hold_in_ready cycle %0d: got %b, required 0", i, in_ready);
      else n_pass++;
    end
    out_ready = 1'b1;
    send("release_add", 4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 1'b1, w);
    n_total++;
    if (w !== 0) $display("FAIL release_accept: waited %0d cycles, required 0", w); else n_pass++;
    send("b2b_sub", 4'h6, 4'h1, 64'd3, 64'd3, 64'd0, 1'b1, w);
    n_total++;
    if (w !== 0) $display("FAIL b2b_accept1: waited %0d cycles, required 0", w); else n_pass++;
    send("b2b_jne", 4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 1'b1, w);
    n_total++;
    if (w !== 0) $display("FAIL b2b_accept2: waited %0d cycles, required 0", w); else n_pass++;
    send("b2b_je", 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b1, w);
    n_total++;
    if (w !== 0) $display("FAIL b2b_accept3: waited %0d cycles, required 0", w); else n_pass++;
    drain("hold");
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    int w, n;
    logic seen;
    send("mulq_6x7", 4'h6, 4'h4, 64'd7, 64'd6, 64'd0, 1'b1, w);
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    n_total++;
    if (n !== W) $display("FAIL mul_busy_cycles: got %0d, required %0d", n, W); else n_pass++;
    drain("mul");
    send("mulq_neg", 4'h6, 4'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd0, 1'b1, w);
    drain("mul_neg");
    send("mulq_rst", 4'h6, 4'h4, 64'd3, 64'd4, 64'd0, 1'b1, w);
    for (int i = 0; i < 5; i++) tick();
    apply_reset();
    n_total++;
    if ({out_valid, cc_zf, cc_sf, cc_of} !== 4'b0100)
      $display("FAIL mul_rst: got valid=%b cc=%b%b%b, required valid=0 cc=100", out_valid, cc_zf, cc_sf, cc_of);
    else n_pass++;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 5; i++) begin tick(); if (out_valid) seen = 1'b1; end
    n_total++;
    if (seen !== 1'b0) $display("FAIL mul_rst_discard: got stale out_valid=1, required 0"); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    icode = 4'h1; ifun = 4'h0; valA = '0; valB = '0; valC = '0; set_cc = 1'b0;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    test_reset();
    test_flags();
    test_stack_and_moves();
    test_errors();
    test_hold_and_back_to_back();
`ifdef EXEC_MUL_EN
    test_mul();
`endif
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
